// File: rtl/io_halfduplex_ctrl.sv
// io_halfduplex_ctrl: direction/turnaround controller for a half-duplex iCE40 pin group.
// Arbitrates one write and one read stream, with guard cycles and read draining on turnaround.
module io_halfduplex_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int IN_LAT      = 2,
  parameter int MAX_BURST   = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             io_oe,
  output logic [WIDTH-1:0] io_dout,
  input  logic [WIDTH-1:0] io_din,
  output logic             dir_tx,
  output logic             busy
);
  typedef enum logic [2:0] {RX, RX_DRAIN, TURN_TX, TX, TURN_RX} state_t;
  localparam int CW = $clog2(MAX_BURST + HOLD_CYCLES + TURN_CYCLES + 2);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] TURN_C = CW'(TURN_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  // The last stage is the rd_valid flop; its data is already captured, so it no longer blocks a turnaround.
  localparam logic [IN_LAT-1:0] EARLY = {IN_LAT{1'b1}} >> 1;
  localparam state_t TO_TX = (TURN_CYCLES == 0) ? TX : TURN_TX;
  localparam state_t TO_RX = (TURN_CYCLES == 0) ? RX : TURN_RX;

  state_t state, nxt;
  logic [CW-1:0] burst, idle, turn;
  logic [IN_LAT-1:0] sr, sr_nxt;
  logic pending, idle_now, leave_rx, leave_tx, turn_done, beat, opp;

  assign pending   = |(sr & EARLY);
  assign idle_now  = !wr_valid && !rd_req;
  assign leave_rx  = wr_valid && (!rd_req || burst >= MAX_C);
  assign leave_tx  = (rd_req && (!wr_valid || burst >= MAX_C)) || (idle_now && idle + ONE >= HOLD_C);
  assign turn_done = turn + ONE >= TURN_C;
  assign sr_nxt    = (sr << 1) | IN_LAT'(rd_ack);
  assign beat      = rd_ack || (wr_valid && wr_ready);
  assign opp       = (state == TX) ? rd_req : wr_valid;
  assign rd_valid  = sr[IN_LAT-1];
  assign dir_tx    = state == TX;
  assign busy      = state != RX || |sr;

  always_comb begin
    nxt      = state;
    wr_ready = 1'b0;
    rd_ack   = 1'b0;
    case (state)
      RX: begin
        rd_ack = rd_req && !leave_rx;
        if (leave_rx) nxt = pending ? RX_DRAIN : TO_TX;
      end
      RX_DRAIN: if (!pending) nxt = TO_TX;
      TURN_TX:  if (turn_done) nxt = TX;
      TX: begin
        wr_ready = !leave_tx;
        if (leave_tx) nxt = TO_RX;
      end
      TURN_RX:  if (turn_done) nxt = RX;
      default:  nxt = RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RX;
      io_oe   <= 1'b0;
      io_dout <= '0;
      sr      <= '0;
      rd_data <= '0;
      burst   <= '0;
      idle    <= '0;
      turn    <= '0;
    end else begin
      state <= nxt;
      io_oe <= nxt == TX;
      sr    <= sr_nxt;
      if (wr_valid && wr_ready) io_dout <= wr_data;
      if (sr_nxt[IN_LAT-1]) rd_data <= io_din;
      turn  <= (nxt == state && (state == TURN_TX || state == TURN_RX)) ? turn + ONE : '0;
      burst <= (nxt != state) ? '0 : !beat ? burst : !opp ? '0 : (burst >= MAX_C) ? burst : burst + ONE;
      idle  <= (state == TX && nxt == TX && idle_now) ? ((idle >= HOLD_C) ? idle : idle + ONE) : '0;
    end
  end
endmodule

// File: tb/tb_io_halfduplex_ctrl.sv
// tb_io_halfduplex_ctrl: scoreboard bench for io_halfduplex_ctrl with default parameters.
module tb_io_halfduplex_ctrl;
  localparam int W = 8, TC = 2, IL = 2, MB = 16, HC = 4;
  logic clk = 0, rst = 1, wr_valid = 0, rd_req = 0;
  logic [W-1:0] wr_data = '0, io_din = '0;
  logic wr_ready, rd_ack, rd_valid, io_oe, dir_tx, busy;
  logic [W-1:0] rd_data, io_dout;
  int n_chk = 0, n_fail = 0, cyc = 0, n_rv = 0;
  typedef struct {int due; logic [W-1:0] data;} rexp_t;
  rexp_t rq[$];
  logic [W-1:0] wq[$];

  io_halfduplex_ctrl #(.WIDTH(W), .TURN_CYCLES(TC), .IN_LAT(IL), .MAX_BURST(MB), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .io_oe(io_oe), .io_dout(io_dout), .io_din(io_din), .dir_tx(dir_tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] din_at(int c);
    return W'((c * 59) ^ 165);
  endfunction

  task automatic rd_expect();
    rexp_t e;
    e.due  = cyc + IL;
    e.data = din_at(cyc + IL - 1);
    rq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_valid) n_rv++;
    while (rq.size() != 0 && rq[0].due < cyc) begin
      chk("rd_missing", 0, 1);
      void'(rq.pop_front());
    end
    if (rq.size() != 0 && rq[0].due == cyc) begin
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, rq[0].data);
      void'(rq.pop_front());
    end else if (rd_valid) chk("stale_rd_valid", rd_valid, 0);
    if (wq.size() != 0) chk("io_dout", io_dout, wq.pop_front());
    io_din = din_at(cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    io_din = din_at(0);
    repeat (2) tick();
    rst = 0;
    chk("rst_io_oe", io_oe, 0);
    chk("rst_io_dout", io_dout, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_dir_tx", dir_tx, 0);
    chk("rst_busy", busy, 0);
    // write-first turnaround from reset
    wr_valid = 1; wr_data = 8'h5A;
    #1;
    chk("rx_wr_ready", wr_ready, 0);
    chk("rx_rd_ack", rd_ack, 0);
    tick();
    chk("turn_tx1_oe", io_oe, 0);
    chk("turn_tx1_wr_ready", wr_ready, 0);
    tick();
    chk("turn_tx2_oe", io_oe, 0);
    tick();
    chk("tx_oe", io_oe, 1);
    chk("tx_dir", dir_tx, 1);
    chk("tx_wr_ready", wr_ready, 1);
    wq.push_back(8'h5A);
    tick();
    // idle hold then release
    wr_valid = 0;
    for (int i = 0; i < HC; i++) begin
      #1;
      chk("hold_oe", io_oe, 1);
      chk("hold_wr_ready", wr_ready, i < HC - 1);
      tick();
    end
    chk("turn_rx1_oe", io_oe, 0);
    chk("turn_rx1_dir", dir_tx, 0);
    chk("turn_rx1_busy", busy, 1);
    tick();
    chk("turn_rx2_oe", io_oe, 0);
    tick();
    chk("rx_busy", busy, 0);
    chk("rx_dout_hold", io_dout, 8'h5A);
    // back-to-back reads
    base = n_rv;
    for (int i = 0; i < 3; i++) begin
      rd_req = 1;
      #1;
      chk("rd_ack", rd_ack, 1);
      rd_expect();
      tick();
    end
    rd_req = 0;
    repeat (4) tick();
    chk("rd_pulses", n_rv - base, 3);
    // read in flight when a write arrives
    rd_req = 1;
    #1;
    chk("drain_ack", rd_ack, 1);
    rd_expect();
    tick();
    rd_req = 0; wr_valid = 1; wr_data = 8'hC3;
    #1;
    chk("drain_rd_ack", rd_ack, 0);
    chk("drain_wr_ready0", wr_ready, 0);
    chk("drain_busy", busy, 1);
    tick();
    chk("drain_oe", io_oe, 0);
    chk("drain_wr_ready1", wr_ready, 0);
    tick();
    chk("drain_turn1_oe", io_oe, 0);
    tick();
    chk("drain_turn2_oe", io_oe, 0);
    tick();
    chk("drain_tx_oe", io_oe, 1);
    chk("drain_tx_wr_ready", wr_ready, 1);
    wq.push_back(8'hC3);
    for (int i = 0; i < 5; i++) begin
      tick();
      wr_data = W'($urandom);
      #1;
      chk("beat_wr_ready", wr_ready, 1);
      wq.push_back(wr_data);
    end
    tick();
    // burst limit with a read pending
    rd_req = 1;
    for (int i = 0; i < MB; i++) begin
      wr_data = W'($urandom);
      #1;
      chk("burst_wr_ready", wr_ready, 1);
      chk("burst_rd_ack", rd_ack, 0);
      wq.push_back(wr_data);
      tick();
    end
    #1;
    chk("burst_stop", wr_ready, 0);
    chk("burst_dir", dir_tx, 1);
    tick();
    chk("burst_turn1_oe", io_oe, 0);
    chk("burst_turn1_ack", rd_ack, 0);
    tick();
    chk("burst_turn2_ack", rd_ack, 0);
    tick();
    chk("burst_rx_ack", rd_ack, 1);
    chk("burst_rx_dir", dir_tx, 0);
    rd_expect();
    tick();
    rd_req = 0; wr_valid = 0;
    repeat (3) tick();
    // reset with a read in flight
    rd_req = 1;
    #1;
    chk("rst_rd_ack", rd_ack, 1);
    tick();
    rd_req = 0; wr_valid = 1;
    #1;
    chk("rst_pre_busy", busy, 1);
    rst = 1;
    rq.delete();
    tick();
    chk("rst_mid_rd_valid", rd_valid, 0);
    chk("rst_mid_oe", io_oe, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 0; wr_valid = 0;
    repeat (3) tick();
    // reset while driving
    wr_valid = 1; wr_data = 8'h96;
    repeat (3) tick();
    chk("rst_tx_dir", dir_tx, 1);
    wq.push_back(8'h96);
    tick();
    rst = 1;
    tick();
    chk("rst_tx_oe", io_oe, 0);
    chk("rst_tx_dout", io_dout, 0);
    chk("rst_tx_dir0", dir_tx, 0);
    chk("rst_tx_rd_valid", rd_valid, 0);
    rst = 0; wr_valid = 0;
    repeat (3) tick();
    chk("post_rst_oe", io_oe, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
